// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types and constants for the writeback arbiter
//
// Purpose : common scalar types, the buffered writeback request struct,
//           default sizing constants and a destination decode helper.
// Ports   : none (package).
package wb_arbiter_pkg;

   typedef logic [4:0]  u5;
   typedef logic [63:0] u64;

   typedef struct packed {
      u5  rd;
      u64 data;
   } wb_req_t;

   localparam int WB_FIFO_DEPTH   = 4;
   localparam int WB_STARVE_LIMIT = 8;

   // One-hot decode of a register index into a 32-bit mask.
   function automatic logic [31:0] rd_onehot(input u5 rd);
      return 32'b1 << rd;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests
//
// Purpose : buffers mul/div results until the register-file write port
//           is free; exposes per-slot validity and destinations so the
//           parent can build a pending-destination mask.
// Ports   : clk, rst (async active-low)
//           enq_valid/enq_ready/enq_data : write side, fires on valid&ready
//           deq_valid/deq_ready/deq_data : read side, fires on valid&ready
//           entry_valid[i]               : slot i currently holds an entry
//           entry_rd[i]                  : destination stored in slot i
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enq_valid,
   output logic                  enq_ready,
   input  wb_req_t               enq_data,
   output logic                  deq_valid,
   input  logic                  deq_ready,
   output wb_req_t               deq_data,
   output logic [DEPTH-1:0]      entry_valid,
   output logic [DEPTH-1:0][4:0] entry_rd
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra bit so full and empty are distinguishable.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]  count;
   logic         enq_fire;
   logic         deq_fire;
   logic [AW-1:0] offset;
   wb_req_t      mem_q [DEPTH];

   assign count     = wr_ptr_q - rd_ptr_q;
   // Full depends on registered occupancy only: a same-cycle dequeue does
   // not open a slot for an enqueue.
   assign enq_ready = (count != (AW+1)'(DEPTH));
   assign deq_valid = (count != '0);
   assign enq_fire  = enq_valid && enq_ready;
   assign deq_fire  = deq_valid && deq_ready;
   assign deq_data  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(enq_fire);
      rd_ptr_d = rd_ptr_q + (AW+1)'(deq_fire);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; validity comes from the pointers.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         mem_q[wr_ptr_q[AW-1:0]] <= enq_data;
      end
   end

   // A slot is live when its distance from the read pointer is below the
   // occupancy.
   always_comb begin
      offset = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = AW'(i) - rd_ptr_q[AW-1:0];
         entry_valid[i] = ({1'b0, offset} < count);
         entry_rd[i]    = mem_q[i].rd;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file writeback arbiter (pipeline vs mul/div)
//
// Purpose : owns the single register-file write port. The in-order
//           pipeline has priority; mul/div results wait in a FIFO and
//           stall the pipeline after losing STARVE_LIMIT times in a row.
// Ports   : clk, rst (async active-low)
//           pipe_valid/pipe_wen/pipe_rd/pipe_data : pipeline result
//           md_valid/md_ready/md_rd/md_data       : mul/div result offer
//           stall_pipe : pipeline input ignored this cycle
//           wdEn/wd/wdData : registered register-file write
//           pend_mask  : destinations held in the FIFO (bit 0 forced 0)
//           commit_cnt : count of non-x0 writes issued
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
   parameter int XLEN         = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pipe_valid,
   input  logic            pipe_wen,
   input  logic [4:0]      pipe_rd,
   input  logic [XLEN-1:0] pipe_data,
   input  logic            md_valid,
   input  logic [4:0]      md_rd,
   input  logic [XLEN-1:0] md_data,
   output logic            md_ready,
   output logic            stall_pipe,
   output logic            wdEn,
   output logic [4:0]      wd,
   output logic [XLEN-1:0] wdData,
   output logic [31:0]     pend_mask,
   output logic [63:0]     commit_cnt
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0]   starve_q, starve_d;
   logic            wd_en_q, wd_en_d;
   logic [4:0]      wd_q, wd_d;
   logic [XLEN-1:0] wd_data_q, wd_data_d;
   logic [63:0]     commit_q, commit_d;

   wb_req_t                   enq_data;
   wb_req_t                   deq_data;
   logic                      fifo_nempty;
   logic                      deq_ready;
   logic [FIFO_DEPTH-1:0]     entry_valid;
   logic [FIFO_DEPTH-1:0][4:0] entry_rd;

   logic pipe_write;
   logic take_pipe;
   logic take_md;

   assign enq_data = '{rd: md_rd, data: u64'(md_data)};

   wb_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .enq_valid   (md_valid),
      .enq_ready   (md_ready),
      .enq_data    (enq_data),
      .deq_valid   (fifo_nempty),
      .deq_ready   (deq_ready),
      .deq_data    (deq_data),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   assign pipe_write = pipe_valid && pipe_wen;
   assign stall_pipe = (starve_q == SW'(STARVE_LIMIT)) && fifo_nempty;
   assign take_pipe  = pipe_write && !stall_pipe;
   // A pipeline slot without a write does not hold off the FIFO head.
   assign deq_ready  = !take_pipe;
   assign take_md    = fifo_nempty && !take_pipe;

   always_comb begin
      wd_en_d   = 1'b0;
      wd_d      = wd_q;
      wd_data_d = wd_data_q;
      if (take_pipe) begin
         wd_en_d   = (pipe_rd != 5'd0);
         wd_d      = pipe_rd;
         wd_data_d = pipe_data;
      end else if (take_md) begin
         wd_en_d   = (deq_data.rd != 5'd0);
         wd_d      = deq_data.rd;
         wd_data_d = XLEN'(deq_data.data);
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (!fifo_nempty || take_md) begin
         starve_d = '0;
      end else if (take_pipe && (starve_q != SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign commit_d = commit_q + 64'(wd_en_d);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q  <= '0;
         wd_en_q   <= 1'b0;
         wd_q      <= '0;
         wd_data_q <= '0;
         commit_q  <= '0;
      end else begin
         starve_q  <= starve_d;
         wd_en_q   <= wd_en_d;
         wd_q      <= wd_d;
         wd_data_q <= wd_data_d;
         commit_q  <= commit_d;
      end
   end

   // Head entry stays visible in the mask until the edge that retires it.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i]) begin
            pend_mask = pend_mask | rd_onehot(entry_rd[i]);
         end
      end
      pend_mask[0] = 1'b0;
   end

   assign wdEn       = wd_en_q;
   assign wd         = wd_q;
   assign wdData     = wd_data_q;
   assign commit_cnt = commit_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_valid, pipe_wen;
   logic [4:0]  pipe_rd;
   logic [63:0] pipe_data;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [63:0] md_data;
   logic        md_ready, stall_pipe, wdEn;
   logic [4:0]  wd;
   logic [63:0] wdData;
   logic [31:0] pend_mask;
   logic [63:0] commit_cnt;

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .XLEN(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_valid (pipe_valid),
      .pipe_wen   (pipe_wen),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .md_valid   (md_valid),
      .md_rd      (md_rd),
      .md_data    (md_data),
      .md_ready   (md_ready),
      .stall_pipe (stall_pipe),
      .wdEn       (wdEn),
      .wd         (wd),
      .wdData     (wdData),
      .pend_mask  (pend_mask),
      .commit_cnt (commit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb_q[$];
   wb_req_t     mq[$];
   int          m_starve = 0;
   logic [63:0] m_commit = '0;
   logic        pipe_acc, md_acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: check combinational outputs against the model, push the
   // expected registered write, advance the model, then compare after the edge.
   task automatic step();
      logic        full, empty, stall, tp, tm;
      logic [31:0] pm;
      exp_t        e;
      #1;
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      stall = (m_starve == LIMIT) && !empty;
      pm = '0;
      foreach (mq[i]) pm[mq[i].rd] = 1'b1;
      pm[0] = 1'b0;
      check("md_ready", 64'(md_ready), 64'(!full));
      check("stall_pipe", 64'(stall_pipe), 64'(stall));
      check("pend_mask", 64'(pend_mask), 64'(pm));
      tp = !stall && pipe_valid && pipe_wen;
      tm = !empty && !tp;
      e = '0;
      if (tp) begin
         e.en = (pipe_rd != 5'd0); e.rd = pipe_rd; e.data = pipe_data;
      end else if (tm) begin
         e.en = (mq[0].rd != 5'd0); e.rd = mq[0].rd; e.data = mq[0].data;
      end
      sb_q.push_back(e);
      pipe_acc = pipe_valid && !stall;
      md_acc   = md_valid && !full;
      if (tm) void'(mq.pop_front());
      if (md_acc) mq.push_back('{rd: md_rd, data: md_data});
      if (empty || tm) m_starve = 0;
      else if (tp && m_starve < LIMIT) m_starve++;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("wdEn", 64'(wdEn), 64'(e.en));
      if (e.en) begin
         check("wd", 64'(wd), 64'(e.rd));
         check("wdData", wdData, e.data);
         m_commit++;
      end
      check("commit_cnt", commit_cnt, m_commit);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step();
      check("drain_pend", 64'(pend_mask), 64'(0));
      check("drain_ready", 64'(md_ready), 64'(1));
   endtask

   initial begin
      int          k, n, cnt;
      logic        saw_full;
      logic [63:0] c0;
      rst = 1'b0;
      pipe_valid = 0; pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
      md_valid = 0; md_rd = 0; md_data = 0;
      #12;
      check("rst_wdEn", 64'(wdEn), 64'(0));
      check("rst_wd", 64'(wd), 64'(0));
      check("rst_wdData", wdData, 64'(0));
      check("rst_commit", commit_cnt, 64'(0));
      check("rst_md_ready", 64'(md_ready), 64'(1));
      check("rst_stall", 64'(stall_pipe), 64'(0));
      check("rst_pend", 64'(pend_mask), 64'(0));
      @(negedge clk);
      rst = 1'b1;

      // md-only stream, pipeline idle
      for (int i = 0; i < 3; i++) begin
         md_valid = 1; md_rd = 5'(5 + 2 * i); md_data = 64'hA + 64'(i);
         step();
      end
      md_valid = 0;
      drain(4);
      check("t1_commit", commit_cnt, 64'd3);

      // FIFO fill under a busy pipeline, held offers
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 5'd2; pipe_data = 64'h100;
      k = 0; saw_full = 0;
      for (int i = 0; i < 80 && k < 6; i++) begin
         md_valid = 1; md_rd = 5'(10 + k); md_data = 64'h200 + 64'(k);
         if (!md_ready) saw_full = 1;
         step();
         if (md_acc) k++;
         if (pipe_acc) pipe_data++;
      end
      md_valid = 0;
      check("t2_all_offered", 64'(k), 64'd6);
      check("t2_full_seen", 64'(saw_full), 64'd1);
      pipe_valid = 0;
      drain(10);

      // starvation limit
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 5'd1; pipe_data = 64'h1111;
      md_valid = 1; md_rd = 5'd20; md_data = 64'h2020;
      step();
      md_valid = 0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (stall_pipe) break;
         step();
         n++;
      end
      check("t3_losses", 64'(n), 64'd8);
      step();
      check("t3_wd", 64'(wd), 64'd20);
      check("t3_stall_clear", 64'(stall_pipe), 64'd0);
      step();
      pipe_valid = 0;
      drain(2);

      // x0 destinations from both sources
      c0 = m_commit;
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 5'd0; pipe_data = 64'hFF;
      md_valid = 1; md_rd = 5'd0; md_data = 64'hEE;
      step();
      pipe_valid = 0; md_valid = 0;
      drain(4);
      check("t4_commit", commit_cnt, c0);

      // simultaneous pipe and md offer at empty FIFO
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 5'd3; pipe_data = 64'h33;
      md_valid = 1; md_rd = 5'd12; md_data = 64'hCC;
      step();
      pipe_valid = 0; md_valid = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (pend_mask[12]) cnt++;
         step();
      end
      check("t5_pend_cycles", 64'(cnt), 64'd1);

      // pipe write with no destination does not block the FIFO
      pipe_valid = 1; pipe_wen = 0; pipe_rd = 5'd9; pipe_data = 64'h99;
      md_valid = 1; md_rd = 5'd17; md_data = 64'h1717;
      step();
      md_valid = 0;
      drain(3);
      pipe_valid = 0;

      // async reset with three entries queued
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 5'd4; pipe_data = 64'h44;
      for (int i = 0; i < 3; i++) begin
         md_valid = 1; md_rd = 5'(21 + i); md_data = 64'h300 + 64'(i);
         step();
      end
      pipe_valid = 0; md_valid = 0;
      check("t6_pend_before", 64'(pend_mask), 64'h00E0_0000);
      #2 rst = 1'b0;
      #1;
      check("t6_wdEn", 64'(wdEn), 64'(0));
      check("t6_wd", 64'(wd), 64'(0));
      check("t6_wdData", wdData, 64'(0));
      check("t6_commit", commit_cnt, 64'(0));
      check("t6_pend", 64'(pend_mask), 64'(0));
      check("t6_md_ready", 64'(md_ready), 64'(1));
      mq.delete(); sb_q.delete(); m_starve = 0; m_commit = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      drain(4);
      check("t6_no_stale", commit_cnt, 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
